// File: rtl/rgb2hsv_pkg.sv
// Shared constants, sector encoding and per-stage side data for the RGB->HSV pipeline.
package rgb2hsv_pkg;

  localparam logic [7:0] HUE_SECTOR = 8'd43;
  localparam logic [7:0] HUE_OFS_G  = 8'd85;
  localparam logic [7:0] HUE_OFS_B  = 8'd171;
  localparam int         LATENCY    = 9;

  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sector_t;

  typedef struct packed {
    logic       valid;
    sector_t    sector;
    logic       sign;
    logic       max_zero;
    logic       delta_zero;
    logic [7:0] v;
  } side_t;

endpackage

// File: rtl/rgb2hsv_if.sv
// Sample bus for the colour converter; pin names mirror hsv2rgb so the two chain directly.
interface rgb2hsv_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       ready_i;
  logic [7:0] h;
  logic [7:0] s;
  logic [7:0] v;
  logic       valid_o;

  modport master (output r, g, b, ready_i, input h, s, v, valid_o);
  modport slave  (input r, g, b, ready_i, output h, s, v, valid_o);
endinterface

// File: rtl/rgb2hsv_div_pipe.sv
// 16/8 unsigned restoring divider, one quotient bit per stage MSB first; 8 cycles latency.
// Fully pipelined with valid and side data carried alongside; no backpressure.
module div_pipe #(
  parameter int SIDE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [15:0]       num_i,
  input  logic [7:0]        den_i,
  input  logic [SIDE_W-1:0] side_i,
  output logic              vld_o,
  output logic [7:0]        quo_o,
  output logic [SIDE_W-1:0] side_o
);

  logic [15:0]       rem_q  [0:6];
  logic [15:0]       rem_d  [0:6];
  logic [7:0]        den_q  [0:6];
  logic [7:0]        quo_q  [0:7];
  logic [7:0]        quo_d  [0:7];
  logic              vld_q  [0:7];
  logic [SIDE_W-1:0] side_q [0:7];

  logic [15:0]       src_rem  [0:7];
  logic [7:0]        src_den  [0:7];
  logic [7:0]        src_quo  [0:7];
  logic              src_vld  [0:7];
  logic [SIDE_W-1:0] src_side [0:7];
  logic [15:0]       trial    [0:7];
  logic [7:0]        ge;

  always_comb begin
    src_rem[0]  = num_i;
    src_den[0]  = den_i;
    src_quo[0]  = '0;
    src_vld[0]  = vld_i;
    src_side[0] = side_i;
    for (int k = 1; k < 8; k++) begin
      src_rem[k]  = rem_q[k-1];
      src_den[k]  = den_q[k-1];
      src_quo[k]  = quo_q[k-1];
      src_vld[k]  = vld_q[k-1];
      src_side[k] = side_q[k-1];
    end
    ge = '0;
    for (int k = 0; k < 8; k++) begin
      trial[k] = {8'd0, src_den[k]} << (7 - k);
      ge[k]    = (src_rem[k] >= trial[k]);
      quo_d[k] = src_quo[k] | (8'(ge[k]) << (7 - k));
    end
    // The last stage only needs the quotient bit, so no remainder is kept past stage 6.
    for (int k = 0; k < 7; k++) begin
      rem_d[k] = ge[k] ? (src_rem[k] - trial[k]) : src_rem[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        quo_q[k]  <= '0;
        vld_q[k]  <= 1'b0;
        side_q[k] <= '0;
      end
      for (int k = 0; k < 7; k++) begin
        rem_q[k] <= '0;
        den_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        quo_q[k]  <= quo_d[k];
        vld_q[k]  <= src_vld[k];
        side_q[k] <= src_side[k];
      end
      for (int k = 0; k < 7; k++) begin
        rem_q[k] <= rem_d[k];
        den_q[k] <= src_den[k];
      end
    end
  end

  assign vld_o  = vld_q[7];
  assign quo_o  = quo_q[7];
  assign side_o = side_q[7];

endmodule

// File: rtl/rgb2hsv.sv
// 8-bit RGB to HSV converter on a 43-step-sector hue circle; sample accepted at edge N appears at N+9.
// One sample per clock, no backpressure; outputs hold the last result between valid pulses.
module rgb2hsv
  import rgb2hsv_pkg::*;
(
  input logic       clock,
  input logic       reset,
  rgb2hsv_if.slave  bus
);

  logic [7:0] r_q, g_q, b_q;
  logic       vld0_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      vld0_q <= 1'b0;
    end else begin
      r_q    <= bus.r;
      g_q    <= bus.g;
      b_q    <= bus.b;
      vld0_q <= bus.ready_i;
    end
  end

  logic [7:0]        mx, mn, dl, hd_abs;
  logic signed [8:0] hd;
  side_t             s0;
  logic [15:0]       sat_num, hue_num;
  logic [7:0]        sat_den, hue_den;

  always_comb begin
    mx = r_q;
    if (g_q > mx) mx = g_q;
    if (b_q > mx) mx = b_q;
    mn = r_q;
    if (g_q < mn) mn = g_q;
    if (b_q < mn) mn = b_q;
    dl = mx - mn;

    s0 = '0;
    // Ties resolve r before g before b.
    if (mx == r_q) begin
      s0.sector = SEC_R;
      hd        = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
    end else if (mx == g_q) begin
      s0.sector = SEC_G;
      hd        = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
    end else begin
      s0.sector = SEC_B;
      hd        = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    end
    hd_abs = hd[8] ? 8'(-hd) : hd[7:0];

    s0.valid      = vld0_q;
    s0.sign       = hd[8];
    s0.max_zero   = (mx == 8'd0);
    s0.delta_zero = (dl == 8'd0);
    s0.v          = mx;

    sat_num = 16'(dl) * 16'd255;
    sat_den = s0.max_zero ? 8'd1 : mx;
    hue_num = 16'(hd_abs) * 16'(HUE_SECTOR);
    hue_den = s0.delta_zero ? 8'd1 : dl;
  end

  logic       sat_vld, hue_vld;
  logic [7:0] sat_quo, hue_quo;
  logic [8:0] sat_side;
  logic [3:0] hue_side;

  div_pipe #(.SIDE_W(9)) u_sat_div (
    .clk    (clock),
    .rst    (reset),
    .vld_i  (s0.valid),
    .num_i  (sat_num),
    .den_i  (sat_den),
    .side_i ({s0.max_zero, s0.v}),
    .vld_o  (sat_vld),
    .quo_o  (sat_quo),
    .side_o (sat_side)
  );

  div_pipe #(.SIDE_W(4)) u_hue_div (
    .clk    (clock),
    .rst    (reset),
    .vld_i  (s0.valid),
    .num_i  (hue_num),
    .den_i  (hue_den),
    .side_i ({s0.sector, s0.sign, s0.delta_zero}),
    .vld_o  (hue_vld),
    .quo_o  (hue_quo),
    .side_o (hue_side)
  );

  side_t      s9;
  logic [7:0] ofs, h_d, s_d;
  logic [7:0] h_q, s_q, v_q;
  logic       valid_q;

  always_comb begin
    s9            = '0;
    s9.valid      = sat_vld & hue_vld;
    s9.max_zero   = sat_side[8];
    s9.v          = sat_side[7:0];
    s9.sector     = sector_t'(hue_side[3:2]);
    s9.sign       = hue_side[1];
    s9.delta_zero = hue_side[0];

    case (s9.sector)
      SEC_R:   ofs = 8'd0;
      SEC_G:   ofs = HUE_OFS_G;
      default: ofs = HUE_OFS_B;
    endcase
    // 8-bit arithmetic gives the mod-256 wrap for negative hue offsets.
    h_d = s9.delta_zero ? 8'd0 : (s9.sign ? (ofs - hue_quo) : (ofs + hue_quo));
    s_d = s9.max_zero ? 8'd0 : sat_quo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      s_q     <= '0;
      v_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= s9.valid;
      if (s9.valid) begin
        h_q <= h_d;
        s_q <= s_d;
        v_q <= s9.v;
      end
    end
  end

  assign bus.h       = h_q;
  assign bus.s       = s_q;
  assign bus.v       = v_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_rgb2hsv.sv
// Self-checking bench for rgb2hsv: directed vectors, streaming, random traffic and mid-stream reset
// against an arithmetic HSV reference model and a due-edge scoreboard.
module tb_rgb2hsv;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rgb2hsv_if bus ();

  rgb2hsv u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int h;
    int s;
    int v;
    int due;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_n   = 0;
  int   held_h   = 0;
  int   held_s   = 0;
  int   held_v   = 0;
  int   nxt_h, nxt_s, nxt_v;

  int dir [9][6] = '{
    '{150, 150, 150,   0,   0, 150},
    '{  0,   0,   0,   0,   0,   0},
    '{255,   0,   0,   0, 255, 255},
    '{  0, 255,   0,  85, 255, 255},
    '{  0,   0, 255, 171, 255, 255},
    '{150, 100,  50,  21, 170, 150},
    '{150,  50, 100, 235, 170, 150},
    '{200, 200,   0,  43, 255, 200},
    '{  0, 200, 200, 128, 255, 200}
  };

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_hsv(input int r, input int g, input int b,
                                  output int h, output int s, output int v);
    int mx, mn, d, off, df, q, ad;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d  = mx - mn;
    v  = mx;
    s  = (mx == 0) ? 0 : (255 * d) / mx;
    if (d == 0) begin
      h = 0;
    end else begin
      if (mx == r)      begin off = 0;   df = g - b; end
      else if (mx == g) begin off = 85;  df = b - r; end
      else              begin off = 171; df = r - g; end
      ad = (df < 0) ? -df : df;
      q  = (43 * ad) / d;
      if (df < 0) q = -q;
      h = (off + q + 256) % 256;
    end
  endfunction

  task automatic tick();
    bit ev;
    @(posedge clock);
    edge_n++;
    if (reset) expq.delete();
    else if (bus.ready_i) expq.push_back('{nxt_h, nxt_s, nxt_v, edge_n + 9});
    @(negedge clock);
    ev = (expq.size() > 0) && (expq[0].due == edge_n);
    check_eq($sformatf("valid_o@%0d", edge_n), int'(bus.valid_o), int'(ev));
    if (ev) begin
      held_h = expq[0].h;
      held_s = expq[0].s;
      held_v = expq[0].v;
      void'(expq.pop_front());
    end
    check_eq($sformatf("h@%0d", edge_n), int'(bus.h), held_h);
    check_eq($sformatf("s@%0d", edge_n), int'(bus.s), held_s);
    check_eq($sformatf("v@%0d", edge_n), int'(bus.v), held_v);
  endtask

  task automatic send(input int r, input int g, input int b,
                      input int eh, input int es, input int ev);
    bus.r       = 8'(r);
    bus.g       = 8'(g);
    bus.b       = 8'(b);
    nxt_h       = eh;
    nxt_s       = es;
    nxt_v       = ev;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic send_model(input int r, input int g, input int b);
    int eh, es, ev;
    ref_hsv(r, g, b, eh, es, ev);
    send(r, g, b, eh, es, ev);
  endtask

  task automatic bubble();
    bus.ready_i = 1'b0;
    bus.r       = 8'($urandom);
    bus.g       = 8'($urandom);
    bus.b       = 8'($urandom);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_h"},     int'(bus.h), 0);
    check_eq({tag, "_s"},     int'(bus.s), 0);
    check_eq({tag, "_v"},     int'(bus.v), 0);
    check_eq({tag, "_valid"}, int'(bus.valid_o), 0);
  endtask

  initial begin
    bus.r       = '0;
    bus.g       = '0;
    bus.b       = '0;
    bus.ready_i = 1'b0;

    #2;
    check_reset_outputs("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Directed vectors back-to-back, then drain.
    for (int i = 0; i < 9; i++)
      send(dir[i][0], dir[i][1], dir[i][2], dir[i][3], dir[i][4], dir[i][5]);
    repeat (12) bubble();

    // Three consecutive strobes followed by bubbles with outputs held.
    send_model(150, 100, 50);
    send_model(0, 255, 0);
    send_model(33, 222, 111);
    repeat (12) bubble();

    // Random traffic with random bubbles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) != 0)
        send_model(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                   int'($urandom_range(255, 0)));
      else
        bubble();
    end
    repeat (12) bubble();

    // Reset with two samples in flight.
    send_model(10, 200, 30);
    send_model(90, 90, 40);
    bubble();
    reset = 1'b1;
    expq.delete();
    held_h = 0;
    held_s = 0;
    held_v = 0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    reset = 1'b0;
    repeat (12) bubble();
    send_model(12, 34, 56);
    repeat (12) bubble();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
